// File: rtl/ibex_rf_write_sequencer.sv
// Register file write-port owner: optional post-reset zero-clear of x1..xN-1,
// then round-robin arbitration of EX/ALU (0) and LSU (1) writebacks onto one registered port.
//
// state | meaning
// INIT  | clearing x1..x(NumWords-1), one register per cycle, requesters stalled
// RUN   | arbitrating requesters onto the write port (terminal until reset)
module ibex_rf_write_sequencer #(
    parameter bit          RV32E        = 1'b0,
    parameter int unsigned DataWidth    = 32,
    parameter bit          ClearOnReset = 1'b1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req0_valid_i,
    output logic                 req0_ready_o,
    input  logic [4:0]           req0_addr_i,
    input  logic [DataWidth-1:0] req0_data_i,
    input  logic                 req1_valid_i,
    output logic                 req1_ready_o,
    input  logic [4:0]           req1_addr_i,
    input  logic [DataWidth-1:0] req1_data_i,
    output logic                 we_o,
    output logic [4:0]           waddr_o,
    output logic [DataWidth-1:0] wdata_o,
    input  logic [4:0]           raddr_a_i,
    input  logic [4:0]           raddr_b_i,
    output logic                 fwd_a_o,
    output logic                 fwd_b_o,
    output logic                 init_done_o,
    output logic                 illegal_addr_o
);

    localparam int unsigned NumWords  = RV32E ? 16 : 32;
    localparam int unsigned AddrWidth = RV32E ? 4 : 5;
    localparam logic [4:0]  LastAddr  = 5'(NumWords - 1);

    typedef enum logic {
        INIT,
        RUN
    } state_e;

    localparam state_e ResetState = ClearOnReset ? INIT : RUN;

    state_e                 state_q, state_d;
    logic [4:0]             cnt_q, cnt_d;
    logic                   prio_q, prio_d;
    logic                   we_q, we_d;
    logic [4:0]             waddr_q, waddr_d;
    logic [DataWidth-1:0]   wdata_q, wdata_d;
    logic                   illegal_q, illegal_d;

    logic                   gnt0, gnt1;
    logic [4:0]             acc_addr;
    logic [DataWidth-1:0]   acc_data;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ResetState;
            cnt_q     <= 5'd1;
            prio_q    <= 1'b0;
            we_q      <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            prio_q    <= prio_d;
            we_q      <= we_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        prio_d    = prio_q;
        we_d      = 1'b0;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        illegal_d = 1'b0;
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        acc_addr  = req0_addr_i;
        acc_data  = req0_data_i;

        case (state_q)
            INIT: begin
                we_d    = 1'b1;
                waddr_d = cnt_q;
                wdata_d = '0;
                if (cnt_q == LastAddr) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            RUN: begin
                // On a tie prio_q names the winner; a lone valid always wins.
                if (req0_valid_i && (!req1_valid_i || !prio_q)) begin
                    gnt0 = 1'b1;
                end else if (req1_valid_i) begin
                    gnt1 = 1'b1;
                end

                if (gnt1) begin
                    acc_addr = req1_addr_i;
                    acc_data = req1_data_i;
                end

                if (gnt0 || gnt1) begin
                    prio_d = gnt0;
                    if (acc_addr == 5'd0) begin
                        we_d = 1'b0;
                    end else if (acc_addr > LastAddr) begin
                        illegal_d = 1'b1;
                    end else begin
                        we_d    = 1'b1;
                        waddr_d = 5'(acc_addr[AddrWidth-1:0]);
                        wdata_d = acc_data;
                    end
                end
            end
            default: begin
                state_d = ResetState;
            end
        endcase
    end

    assign req0_ready_o   = gnt0;
    assign req1_ready_o   = gnt1;
    assign we_o           = we_q;
    assign waddr_o        = waddr_q;
    assign wdata_o        = wdata_q;
    assign illegal_addr_o = illegal_q;
    assign init_done_o    = (state_q == RUN);

    // Forwarding looks only at the implemented address bits.
    assign fwd_a_o = we_q && (waddr_q[AddrWidth-1:0] == raddr_a_i[AddrWidth-1:0]);
    assign fwd_b_o = we_q && (waddr_q[AddrWidth-1:0] == raddr_b_i[AddrWidth-1:0]);

    logic unused_raddr;
    assign unused_raddr = ^{raddr_a_i, raddr_b_i};

endmodule

// File: tb/tb_ibex_rf_write_sequencer.sv
// Scoreboard bench for ibex_rf_write_sequencer: a 32-register and a 16-register instance
// driven by the same request streams, each predicted by its own arbitration/address model.
module tb_ibex_rf_write_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        v0[2], v1[2], r0[2], r1[2], we[2], fa[2], fb[2], idone[2], ill[2];
    logic [4:0]  a0[2], a1[2], ra[2], rb[2], wa[2];
    logic [31:0] d0[2], d1[2], wd[2];

    ibex_rf_write_sequencer #(.RV32E(1'b0), .DataWidth(32), .ClearOnReset(1'b1)) u_dut32 (
        .clk_i(clk), .rst_ni(rst_n),
        .req0_valid_i(v0[0]), .req0_ready_o(r0[0]), .req0_addr_i(a0[0]), .req0_data_i(d0[0]),
        .req1_valid_i(v1[0]), .req1_ready_o(r1[0]), .req1_addr_i(a1[0]), .req1_data_i(d1[0]),
        .we_o(we[0]), .waddr_o(wa[0]), .wdata_o(wd[0]),
        .raddr_a_i(ra[0]), .raddr_b_i(rb[0]), .fwd_a_o(fa[0]), .fwd_b_o(fb[0]),
        .init_done_o(idone[0]), .illegal_addr_o(ill[0])
    );

    ibex_rf_write_sequencer #(.RV32E(1'b1), .DataWidth(32), .ClearOnReset(1'b1)) u_dut16 (
        .clk_i(clk), .rst_ni(rst_n),
        .req0_valid_i(v0[1]), .req0_ready_o(r0[1]), .req0_addr_i(a0[1]), .req0_data_i(d0[1]),
        .req1_valid_i(v1[1]), .req1_ready_o(r1[1]), .req1_addr_i(a1[1]), .req1_data_i(d1[1]),
        .we_o(we[1]), .waddr_o(wa[1]), .wdata_o(wd[1]),
        .raddr_a_i(ra[1]), .raddr_b_i(rb[1]), .fwd_a_o(fa[1]), .fwd_b_o(fb[1]),
        .init_done_o(idone[1]), .illegal_addr_o(ill[1])
    );

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } item_t;

    typedef struct packed {
        int          cyc;
        logic        we;
        logic        ill;
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    item_t rq[2][2][256];
    int    rq_wr[2][2], rq_rd[2][2];
    item_t cur[2][2];
    bit    act[2][2];
    exp_t  sb[2][256];
    int    sb_wr[2], sb_rd[2];
    int    run_cyc[2];
    bit    prio[2];
    int    cyc = 0;
    int    checks = 0, errors = 0;
    int    rate = 100;
    bit    fix_raddr = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int nw(int d);
        return (d == 0) ? 32 : 16;
    endfunction

    task automatic chk(string name, int d, logic [31:0] act_v, logic [31:0] exp_v);
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL %s dut%0d cyc %0d: got %0h expected %0h", name, d, cyc, act_v, exp_v);
        end
    endtask

    task automatic load(int r, logic [4:0] addr, logic [31:0] data);
        for (int d = 0; d < 2; d++) begin
            rq[d][r][rq_wr[d][r] % 256] = '{addr: addr, data: data};
            rq_wr[d][r]++;
        end
    endtask

    // Expected port activity for one accepted request or one clear step.
    task automatic push_exp(int d, int c, logic [4:0] addr, logic [31:0] data);
        exp_t e;
        e.cyc  = c;
        e.addr = addr;
        e.data = data;
        e.we   = (addr != 5'd0) && (int'(addr) < nw(d));
        e.ill  = (int'(addr) >= nw(d));
        sb[d][sb_wr[d] % 256] = e;
        sb_wr[d]++;
    endtask

    task automatic step();
        int g;
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            for (int r = 0; r < 2; r++) begin
                if (!act[d][r] && rq_rd[d][r] != rq_wr[d][r] && $urandom_range(1, 100) <= rate) begin
                    cur[d][r] = rq[d][r][rq_rd[d][r] % 256];
                    rq_rd[d][r]++;
                    act[d][r] = 1'b1;
                end
            end
            v0[d] = act[d][0]; a0[d] = cur[d][0].addr; d0[d] = cur[d][0].data;
            v1[d] = act[d][1]; a1[d] = cur[d][1].addr; d1[d] = cur[d][1].data;
            if (!fix_raddr) begin
                ra[d] = $urandom_range(0, 1) ? cur[d][0].addr : 5'($urandom_range(0, 31));
                rb[d] = $urandom_range(0, 1) ? cur[d][1].addr : 5'($urandom_range(0, 31));
            end
        end
        #1;
        if (rst_n) begin
            for (int d = 0; d < 2; d++) begin
                g = -1;
                if (cyc >= run_cyc[d]) begin
                    if (act[d][0] && act[d][1]) g = int'(prio[d]);
                    else if (act[d][0]) g = 0;
                    else if (act[d][1]) g = 1;
                end
                chk("ready0", d, 32'(r0[d]), 32'(g == 0));
                chk("ready1", d, 32'(r1[d]), 32'(g == 1));
                if (g >= 0) begin
                    push_exp(d, cyc + 1, cur[d][g].addr, cur[d][g].data);
                    act[d][g] = 1'b0;
                    prio[d]   = (g == 0);
                end
            end
        end
    endtask

    function automatic bit idle();
        for (int d = 0; d < 2; d++)
            for (int r = 0; r < 2; r++)
                if (act[d][r] || rq_rd[d][r] != rq_wr[d][r]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic drain();
        int n = 0;
        while ((!idle() || cyc < run_cyc[0] + 1) && n < 3000) begin
            step();
            n++;
        end
        checks++;
        if (n >= 3000) begin
            errors++;
            $display("FAIL drain_timeout cyc %0d: got pending requests expected none", cyc);
        end
        step();
        step();
    endtask

    task automatic do_reset();
        int c;
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            sb_wr[d] = 0; sb_rd[d] = 0; prio[d] = 1'b0; run_cyc[d] = 1 << 30;
            v0[d] = 1'b0; v1[d] = 1'b0;
            for (int r = 0; r < 2; r++) begin
                act[d][r] = 1'b0; rq_wr[d][r] = 0; rq_rd[d][r] = 0;
            end
        end
        repeat (3) @(negedge clk);
        c = cyc;
        for (int d = 0; d < 2; d++) begin
            for (int k = 1; k < nw(d); k++) push_exp(d, c + k, 5'(k), 32'd0);
            run_cyc[d] = c + nw(d) - 1;
        end
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin : monitor
        exp_t me;
        logic [4:0] m;
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                chk("rst_we", d, 32'(we[d]), 32'd0);
                chk("rst_waddr", d, 32'(wa[d]), 32'd0);
                chk("rst_wdata", d, wd[d], 32'd0);
                chk("rst_illegal", d, 32'(ill[d]), 32'd0);
                chk("rst_init_done", d, 32'(idone[d]), 32'd0);
            end else begin
                while (sb_rd[d] != sb_wr[d] && sb[d][sb_rd[d] % 256].cyc < cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL missed_write dut%0d cyc %0d: got nothing expected addr %0d",
                             d, cyc, sb[d][sb_rd[d] % 256].addr);
                    sb_rd[d]++;
                end
                me = '0;
                if (sb_rd[d] != sb_wr[d] && sb[d][sb_rd[d] % 256].cyc == cyc) begin
                    me = sb[d][sb_rd[d] % 256];
                    sb_rd[d]++;
                end
                chk("we", d, 32'(we[d]), 32'(me.we));
                if (me.we) begin
                    chk("waddr", d, 32'(wa[d]), 32'(me.addr));
                    chk("wdata", d, wd[d], me.data);
                end
                chk("illegal", d, 32'(ill[d]), 32'(me.ill));
                chk("init_done", d, 32'(idone[d]), 32'(cyc >= run_cyc[d]));
                m = (d == 0) ? 5'h1f : 5'h0f;
                chk("fwd_a", d, 32'(fa[d]), 32'(me.we && ((me.addr & m) == (ra[d] & m))));
                chk("fwd_b", d, 32'(fb[d]), 32'(me.we && ((me.addr & m) == (rb[d] & m))));
            end
        end
    end

    initial begin
        int c0;
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            v0[d] = 1'b0; v1[d] = 1'b0; a0[d] = '0; a1[d] = '0;
            d0[d] = '0; d1[d] = '0; ra[d] = '0; rb[d] = '0;
            cur[d][0] = '0; cur[d][1] = '0;
        end

        // Clear sequence with a simultaneous pair held through it.
        do_reset();
        load(0, 5'd5, 32'hA5);
        load(1, 5'd6, 32'h5A);
        drain();

        // Continuous contention.
        for (int i = 0; i < 6; i++) begin
            load(0, 5'(1 + i), 32'h100 + i);
            load(1, 5'(8 + i), 32'h200 + i);
        end
        drain();

        // Dropped x0 write still flips priority.
        load(0, 5'd0, 32'hFF);
        drain();
        load(0, 5'd7, 32'h77);
        load(1, 5'd8, 32'h88);
        drain();

        // Out-of-range for the 16-register instance, then a normal write.
        load(1, 5'd17, 32'h1717);
        drain();
        load(1, 5'd3, 32'h33);
        drain();

        // Bypass flags.
        fix_raddr = 1'b1;
        for (int d = 0; d < 2; d++) begin
            ra[d] = 5'd9;
            rb[d] = 5'd10;
        end
        load(0, 5'd9, 32'h99);
        drain();
        fix_raddr = 1'b0;

        // Reset in the middle of the clear sequence.
        do_reset();
        c0 = run_cyc[0] - 31;
        while (cyc < c0 + 12) begin
            @(posedge clk);
            #1;
        end
        chk("mid_init_waddr", 0, 32'(wa[0]), 32'd12);
        chk("mid_init_waddr", 1, 32'(wa[1]), 32'd12);
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("async_rst_we", d, 32'(we[d]), 32'd0);
            chk("async_rst_waddr", d, 32'(wa[d]), 32'd0);
            chk("async_rst_init_done", d, 32'(idone[d]), 32'd0);
        end
        do_reset();

        // Random traffic, including during the restarted clear.
        rate = 70;
        for (int i = 0; i < 150; i++) begin
            load(0, 5'($urandom_range(0, 31)), $urandom);
            load(1, 5'($urandom_range(0, 31)), $urandom);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
